// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO drain arbiter: destination field width,
// arbiter state encoding and a macro that extracts the destination field
// (top DEST_W bits) from a word.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

   localparam int DEST_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

endpackage

// Destination field of a word variable of width ws (argument must be a variable).
`define FIFO_ARB_DEST(word, ws) word[(ws)-1 -: fifo_arb_pkg::DEST_W]

// File: rtl/fifo_drain_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_drain_arbiter_if
// Bundles the input-FIFO read side and output-FIFO write side seen by the
// drain arbiter.
//   master : the arbiter (drives in_rd, out_wr, out_data, grant, idle)
//   slave  : the FIFO banks / environment (drives in_empty, in_data,
//            out_almost_full)
// -----------------------------------------------------------------------------
interface fifo_drain_arbiter_if #(
   parameter int WORD_SIZE = 6,
   parameter int NUM_FIFO  = 4
);

   logic [NUM_FIFO-1:0]           in_empty;
   logic [NUM_FIFO*WORD_SIZE-1:0] in_data;
   logic [NUM_FIFO-1:0]           in_rd;
   logic [NUM_FIFO-1:0]           out_almost_full;
   logic [NUM_FIFO-1:0]           out_wr;
   logic [WORD_SIZE-1:0]          out_data;
   logic [1:0]                    grant;
   logic                          idle;

   modport master (
      input  in_empty, in_data, out_almost_full,
      output in_rd, out_wr, out_data, grant, idle
   );

   modport slave (
      output in_empty, in_data, out_almost_full,
      input  in_rd, out_wr, out_data, grant, idle
   );

endinterface

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Rotate-priority encoder: finds the first set bit of req starting at index
// start and wrapping, so start has highest priority and start-1 the lowest.
// Pure combinational.
//   req   in  4  request vector
//   start in  2  highest-priority index
//   found out 1  any request set
//   index out 2  selected request (== start when none found)
// -----------------------------------------------------------------------------
module rr_select (
   input  logic [3:0] req,
   input  logic [1:0] start,
   output logic       found,
   output logic [1:0] index
);

   logic [1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   // NOTE: every always_comb output gets a default first; a path that leaves a
   // variable unassigned would infer a latch.
   always_comb begin
      found = 1'b0;
      index = start;
      cand  = start;
      for (int k = 3; k >= 0; k--) begin
         cand = start + 2'(k);
         if (req[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_drain_arbiter
// Drains NUM_FIFO first-word-fall-through input FIFOs, routes each word by its
// destination field (top 2 bits) to one of NUM_FIFO output FIFOs through a
// one-stage output register. Round-robin with a per-grant burst limit; a
// source is eligible only if its head's destination is not almost_full.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high
//   bus       master modport of fifo_drain_arbiter_if:
//               in_empty/in_data/out_almost_full in, in_rd (comb) out,
//               out_wr/out_data/grant/idle (registered) out
//   word_cnt  out  NUM_FIFO*8, per-output saturating push counters
//                  (only when DRAIN_STATS_EN is defined)
//
// Optional feature macro: DRAIN_STATS_EN
// -----------------------------------------------------------------------------
module fifo_drain_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WORD_SIZE = 6,
   parameter int NUM_FIFO  = 4,
   parameter int BURST     = 4
) (
   input logic                 clk,
   input logic                 reset,
   fifo_drain_arbiter_if.master bus
`ifdef DRAIN_STATS_EN
   ,
   output logic [NUM_FIFO*8-1:0] word_cnt
`endif
);

   localparam logic [3:0] BURST_LIM = 4'(BURST);

   // Registered state
   arb_state_e           state_q, state_d;
   logic [1:0]           grant_q, grant_d;
   logic [3:0]           burst_cnt_q, burst_cnt_d;
   logic [NUM_FIFO-1:0]  out_wr_q, out_wr_d;
   logic [WORD_SIZE-1:0] out_data_q, out_data_d;
   logic                 idle_q, idle_d;

   // Combinational
   logic [WORD_SIZE-1:0] head [NUM_FIFO];
   logic [NUM_FIFO-1:0]  eligible;
   logic [1:0]           rr_start;
   logic                 rr_found;
   logic [1:0]           rr_index;
   logic                 keep_grant;
   logic                 pop;
   logic [1:0]           pop_idx;
   logic [WORD_SIZE-1:0] pop_word;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_FIFO; i++) begin
         head[i]     = bus.in_data[i*WORD_SIZE +: WORD_SIZE];
         eligible[i] = !bus.in_empty[i] &&
                       !bus.out_almost_full[`FIFO_ARB_DEST(head[i], WORD_SIZE)];
      end
   end

   // Search starts one past the current grant; the current holder is checked
   // last, so a lone eligible source is re-granted after its burst expires.
   assign rr_start = grant_q + 2'd1;

   rr_select u_rr_select (
      .req   (eligible),
      .start (rr_start),
      .found (rr_found),
      .index (rr_index)
   );

   assign keep_grant = (state_q == ST_GRANT) && eligible[grant_q] &&
                       (burst_cnt_q < BURST_LIM);

   always_comb begin
      pop         = 1'b0;
      pop_idx     = grant_q;
      state_d     = state_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      if (keep_grant) begin
         pop         = 1'b1;
         burst_cnt_d = burst_cnt_q + 4'd1;
         state_d     = ST_GRANT;
      end else if (rr_found) begin
         pop         = 1'b1;
         pop_idx     = rr_index;
         grant_d     = rr_index;
         burst_cnt_d = 4'd1;
         state_d     = ST_GRANT;
      end else begin
         state_d     = ST_IDLE;
      end

      pop_word   = head[pop_idx];
      out_wr_d   = '0;
      out_data_d = out_data_q;
      if (pop) begin
         out_wr_d   = NUM_FIFO'(1) << `FIFO_ARB_DEST(pop_word, WORD_SIZE);
         out_data_d = pop_word;
      end
      idle_d = (state_d == ST_IDLE);
   end

   // Pop strobe is combinational so the FIFO head advances on this edge;
   // suppressed during reset so nothing is consumed while flops are cleared.
   assign bus.in_rd = (pop && !reset) ? (NUM_FIFO'(1) << pop_idx) : '0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= 2'd3;
         burst_cnt_q <= '0;
         out_wr_q    <= '0;
         out_data_q  <= '0;
         idle_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         burst_cnt_q <= burst_cnt_d;
         out_wr_q    <= out_wr_d;
         out_data_q  <= out_data_d;
         idle_q      <= idle_d;
      end
   end

   assign bus.out_wr   = out_wr_q;
   assign bus.out_data = out_data_q;
   assign bus.grant    = grant_q;
   assign bus.idle     = idle_q;

`ifdef DRAIN_STATS_EN
   logic [7:0] cnt_q [NUM_FIFO];
   logic [7:0] cnt_d [NUM_FIFO];

   // Count actual pushes (registered out_wr), saturating at 255.
   always_comb begin
      for (int i = 0; i < NUM_FIFO; i++) begin
         cnt_d[i] = cnt_q[i];
         if (out_wr_q[i] && (cnt_q[i] != 8'hFF)) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_FIFO; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FIFO; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_FIFO; i++) begin
         word_cnt[i*8 +: 8] = cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_arbiter
// Self-checking bench: input FIFOs are modelled as queues, the expected pop
// order and output pushes are queued by each test when it loads stimulus and
// are popped by a monitor when the DUT pops / pushes.
// -----------------------------------------------------------------------------
module tb_fifo_drain_arbiter;

   localparam int WS = 6;
   localparam int NF = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fifo_drain_arbiter_if #(.WORD_SIZE(WS), .NUM_FIFO(NF)) bus ();

`ifdef DRAIN_STATS_EN
   logic [NF*8-1:0] word_cnt;
`endif

   fifo_drain_arbiter #(.WORD_SIZE(WS), .NUM_FIFO(NF), .BURST(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DRAIN_STATS_EN
      ,
      .word_cnt (word_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Input FIFO models and scoreboard
   logic [WS-1:0] fq [NF][$];
   int            exp_pop [$];
   logic [NF-1:0] exp_wr  [$];
   logic [WS-1:0] exp_dat [$];
   logic [NF-1:0] pend_rd = '0;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic refresh();
      for (int i = 0; i < NF; i++) begin
         bus.in_empty[i] = (fq[i].size() == 0);
         bus.in_data[i*WS +: WS] = (fq[i].size() != 0) ? fq[i][0] : '0;
      end
   endtask

   // FIFO heads advance just after the edge on which they were popped.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NF; i++) begin
         if (pend_rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
      end
      pend_rd = '0;
      refresh();
   end

   // Monitor: compares each pop and each push against the scoreboard.
   always @(negedge clk) begin : mon
      int            e;
      logic [NF-1:0] one;
      logic [NF-1:0] ew;
      logic [WS-1:0] ed;
      one = 1;
      if (reset) begin
         pend_rd = '0;
      end else begin
         pend_rd = bus.in_rd;
         if (bus.in_rd != '0) begin
            n_chk++;
            if (exp_pop.size() == 0) begin
               $display("FAIL pop_unexpected: in_rd=%b, required none", bus.in_rd);
            end else begin
               e = exp_pop.pop_front();
               if (bus.in_rd !== (one << e))
                  $display("FAIL pop_order: in_rd=%b, required %b", bus.in_rd, one << e);
               else
                  n_pass++;
            end
         end
         if (bus.out_wr != '0) begin
            n_chk++;
            if (exp_wr.size() == 0) begin
               $display("FAIL push_unexpected: out_wr=%b data=%h", bus.out_wr, bus.out_data);
            end else begin
               ew = exp_wr.pop_front();
               ed = exp_dat.pop_front();
               if (bus.out_wr !== ew || bus.out_data !== ed)
                  $display("FAIL push_value: out_wr=%b data=%h, required out_wr=%b data=%h",
                           bus.out_wr, bus.out_data, ew, ed);
               else
                  n_pass++;
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_pop(input int src, input logic [WS-1:0] w);
      logic [NF-1:0] one;
      one = 1;
      exp_pop.push_back(src);
      exp_wr.push_back(one << w[WS-1 -: 2]);
      exp_dat.push_back(w);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < NF; i++) fq[i].delete();
      exp_pop.delete();
      exp_wr.delete();
      exp_dat.delete();
      bus.out_almost_full = '0;
      refresh();
      sync();
      sync();
      reset = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int max_cyc, output int cycles);
      cycles = 0;
      while (exp_pop.size() != 0 && cycles < max_cyc) begin
         sync();
         cycles++;
      end
      if (exp_pop.size() != 0) begin
         n_chk++;
         $display("FAIL %s_timeout: %0d pops outstanding after %0d cycles",
                  name, exp_pop.size(), cycles);
      end
      sync();
      sync();
      n_chk++;
      if (exp_wr.size() != 0)
         $display("FAIL %s_push_drain: %0d pushes outstanding, required 0", name, exp_wr.size());
      else
         n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.out_almost_full = '0;
      for (int i = 0; i < NF; i++) fq[i].push_back(6'(i));
      refresh();
      sync();
      sync();
      @(negedge clk);
      n_chk += 5;
      if (bus.in_rd !== 4'b0000) $display("FAIL reset_in_rd: %b, required 0000", bus.in_rd);
      else n_pass++;
      if (bus.out_wr !== 4'b0000) $display("FAIL reset_out_wr: %b, required 0000", bus.out_wr);
      else n_pass++;
      if (bus.out_data !== 6'h00) $display("FAIL reset_out_data: %h, required 00", bus.out_data);
      else n_pass++;
      if (bus.grant !== 2'd3) $display("FAIL reset_grant: %0d, required 3", bus.grant);
      else n_pass++;
      if (bus.idle !== 1'b1) $display("FAIL reset_idle: %b, required 1", bus.idle);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_single();
      int cyc;
      do_reset();
      fq[0].push_back(6'h25);
      expect_pop(0, 6'h25);
      refresh();
      sync();
      n_chk += 3;
      if (bus.out_wr !== 4'b0100) $display("FAIL single_out_wr: %b, required 0100", bus.out_wr);
      else n_pass++;
      if (bus.out_data !== 6'h25) $display("FAIL single_out_data: %h, required 25", bus.out_data);
      else n_pass++;
      if (bus.idle !== 1'b0) $display("FAIL single_busy: idle=%b, required 0", bus.idle);
      else n_pass++;
      sync();
      n_chk += 4;
      if (bus.idle !== 1'b1) $display("FAIL single_idle: %b, required 1", bus.idle);
      else n_pass++;
      if (bus.out_wr !== 4'b0000) $display("FAIL single_wr_clear: %b, required 0000", bus.out_wr);
      else n_pass++;
      if (bus.out_data !== 6'h25) $display("FAIL single_data_hold: %h, required 25", bus.out_data);
      else n_pass++;
      if (bus.grant !== 2'd0) $display("FAIL single_grant: %0d, required 0", bus.grant);
      else n_pass++;
      wait_drain("single", 5, cyc);
   endtask

   task automatic test_round_robin();
      int order [24] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0, 1,1, 2,2, 3,3};
      int cnt [NF] = '{0, 0, 0, 0};
      int cyc;
      do_reset();
      for (int s = 0; s < NF; s++)
         for (int k = 0; k < 6; k++) fq[s].push_back({2'b00, 2'(s), 2'(k)});
      for (int n = 0; n < 24; n++) begin
         expect_pop(order[n], {2'b00, 2'(order[n]), 2'(cnt[order[n]])});
         cnt[order[n]]++;
      end
      refresh();
      wait_drain("round_robin", 60, cyc);
      n_chk++;
      if (cyc != 24) $display("FAIL rr_throughput: %0d cycles, required 24", cyc);
      else n_pass++;
   endtask

   task automatic test_burst_single();
      int cyc;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         fq[2].push_back({2'b01, 4'(k)});
         expect_pop(2, {2'b01, 4'(k)});
      end
      refresh();
      wait_drain("burst_single", 20, cyc);
      n_chk++;
      if (cyc != 6) $display("FAIL burst_regrant: %0d cycles, required 6", cyc);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int cyc;
      do_reset();
      bus.out_almost_full = 4'b1000;
      fq[1].push_back(6'h31);
      fq[2].push_back(6'h02);
      expect_pop(2, 6'h02);
      expect_pop(1, 6'h31);
      refresh();
      sync();
      sync();
      sync();
      n_chk += 3;
      if (exp_pop.size() != 1) $display("FAIL bp_hold: %0d pops outstanding, required 1", exp_pop.size());
      else n_pass++;
      if (fq[1].size() != 1) $display("FAIL bp_fifo1: %0d words left, required 1", fq[1].size());
      else n_pass++;
      if (bus.idle !== 1'b1) $display("FAIL bp_idle: %b, required 1", bus.idle);
      else n_pass++;
      bus.out_almost_full = 4'b0000;
      wait_drain("backpressure", 10, cyc);
      n_chk++;
      if (bus.grant !== 2'd1) $display("FAIL bp_grant: %0d, required 1", bus.grant);
      else n_pass++;
   endtask

   task automatic test_mid_burst_empty();
      int cyc;
      do_reset();
      for (int k = 0; k < 2; k++) fq[0].push_back({2'b10, 4'(k)});
      for (int k = 0; k < 3; k++) fq[3].push_back({2'b11, 4'(k)});
      expect_pop(0, 6'h20);
      expect_pop(0, 6'h21);
      expect_pop(3, 6'h30);
      expect_pop(3, 6'h31);
      expect_pop(3, 6'h32);
      refresh();
      wait_drain("mid_burst", 20, cyc);
      n_chk++;
      if (cyc != 5) $display("FAIL mid_burst_rotation: %0d cycles, required 5", cyc);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      fq[0].push_back(6'h11);
      fq[0].push_back(6'h12);
      expect_pop(0, 6'h11);
      refresh();
      sync();
      n_chk++;
      if (bus.out_wr !== 4'b0010) $display("FAIL rst_mid_pre: out_wr=%b, required 0010", bus.out_wr);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_chk += 2;
      if (bus.out_wr !== 4'b0000) $display("FAIL rst_mid_out_wr: %b, required 0000", bus.out_wr);
      else n_pass++;
      if (bus.in_rd !== 4'b0000) $display("FAIL rst_mid_in_rd: %b, required 0000", bus.in_rd);
      else n_pass++;
      do_reset();
   endtask

`ifdef DRAIN_STATS_EN
   task automatic test_stats();
      int cyc;
      do_reset();
      for (int k = 0; k < 300; k++) begin
         fq[0].push_back({2'b01, 4'(k)});
         expect_pop(0, {2'b01, 4'(k)});
      end
      refresh();
      wait_drain("stats", 400, cyc);
      n_chk += 2;
      if (word_cnt[15:8] !== 8'd255) $display("FAIL stats_sat: %0d, required 255", word_cnt[15:8]);
      else n_pass++;
      if ({word_cnt[31:16], word_cnt[7:0]} !== 24'd0)
         $display("FAIL stats_other: %h, required 0", {word_cnt[31:16], word_cnt[7:0]});
      else n_pass++;
      do_reset();
      n_chk++;
      if (word_cnt !== '0) $display("FAIL stats_reset: %h, required 0", word_cnt);
      else n_pass++;
   endtask
`endif

   initial begin
      bus.out_almost_full = '0;
      refresh();
      test_reset();
      test_single();
      test_round_robin();
      test_burst_single();
      test_backpressure();
      test_mid_burst_empty();
      test_reset_mid();
`ifdef DRAIN_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_drain_arbiter.md
# fifo_drain_arbiter

Reader side of the interconnect FIFOs: drains NUM_FIFO input FIFOs (first-word-fall-through heads), routes each word by its destination field to one of NUM_FIFO output FIFOs, and pushes it through a one-stage output register. Round-robin arbitration with a per-grant burst limit. A source is eligible only when its head word's destination FIFO is not almost_full. Sits between the input FIFO bank and the output FIFO bank.

## Interface
- WORD_SIZE, 6, bits per word; destination field is word[WORD_SIZE-1:WORD_SIZE-2]
- NUM_FIFO, 4, input and output FIFO count; fixed at 4 (2-bit destination)
- BURST, 4, max consecutive pops from one source before forced rotation (1..15)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_empty  in  NUM_FIFO  fifo_empty of each input FIFO
- in_data  in  NUM_FIFO*WORD_SIZE  head word of each input FIFO, slice i = [i*WORD_SIZE +: WORD_SIZE]
- in_rd  out  NUM_FIFO  one-hot pop strobe to input FIFO fifo_rd (combinational)
- out_almost_full  in  NUM_FIFO  almost_full of each output FIFO
- out_wr  out  NUM_FIFO  one-hot push strobe to output FIFO fifo_wr (registered)
- out_data  out  WORD_SIZE  word to all output FIFO fifo_data_in (registered)
- grant  out  2  current grant index (registered)
- idle  out  1  high when no pop occurred this cycle's state (registered, state==IDLE)

## Operation
- dest(i) = in_data slice i, top 2 bits. eligible[i] = !in_empty[i] && !out_almost_full[dest(i)].
- Registered state: state {IDLE, GRANT}, grant (2b), burst_cnt (4b).
- Per cycle: if state==GRANT, eligible[grant], burst_cnt<BURST -> pop grant, burst_cnt+1.
- Otherwise search eligible starting at grant+1 mod 4, wrapping, grant itself checked last. Found j -> pop j, grant<=j, burst_cnt<=1, state<=GRANT. None -> no pop, state<=IDLE, grant/burst_cnt hold.
- At most one in_rd bit per cycle; never asserted on an empty or non-eligible source.
- Pop of source j in cycle N: out_data<=in_data slice j, out_wr<=one-hot(dest(j)) at edge ending N; cycles with no pop -> out_wr<=0, out_data holds.
- Reset: state=IDLE, grant=3 (first search starts at 0), burst_cnt=0, out_wr=0, out_data=0, idle=1; in_rd forced 0 while reset high.

## Timing
- Latency input pop -> output push: 1 cycle. Throughput 1 word/cycle, no bubble on rotation.
- almost_full is sampled in the pop cycle; one word may be in flight in the output register, so output FIFO full_threshold must leave >=2 free entries.
- Input FIFO empty must update on the edge following a pop; back-to-back pops of a 1-entry FIFO are prevented by that update.
- Same-cycle almost_full rise and head arrival: word not popped.
- Reset mid-operation: in-flight out_wr dropped immediately (async clear); popped word is lost by design.

## Configuration
- DRAIN_STATS_EN defined: adds output port word_cnt (NUM_FIFO*8 bits), per-output 8-bit saturating counters incremented on each out_wr bit, cleared by reset, saturate at 255.
- Undefined: no port, no counters; all other behaviour identical.

## Structure
- Shared package/include fifo_arb_pkg: DEST_W=2, state encodings ST_IDLE=0, ST_GRANT=1, dest-field extraction macro.
- One sub-module rr_select: 4-bit request, 2-bit start index -> found flag + 2-bit index (pure combinational rotate-priority encoder).

## Test plan
- Reset: hold reset with all inputs non-empty -> in_rd=0, out_wr=0, out_data=0, grant=3, idle=1.
- Single word: FIFO0 head 0x25 (dest 2), rest empty -> in_rd=0001 cycle N, out_wr=0100, out_data=0x25 cycle N+1, then idle=1.
- Round-robin/burst: all four FIFOs hold 6 words to dest 0, BURST=4 -> pops 0,0,0,0,1,1,1,1,2,... no bubbles.
- Backpressure: FIFO1 head dest 3, out_almost_full=1000 -> FIFO1 skipped, FIFO2 (dest 0) served; drop almost_full -> FIFO1 served next rotation.
- Mid-burst empty: FIFO0 has 2 words, FIFO3 has 3 -> 0,0,3,3,3 with rotation in the same cycle FIFO0 empties.
- DRAIN_STATS_EN: 300 words to dest 1 -> word_cnt slice 1 = 255, other slices 0; reset clears to 0.
